gf180mcu_fd_sc_mcu7t5v0__xnor3_bist: RTL



---
 rtl/gf180mcu_fd_sc_mcu7t5v0__xnor3_bist_if.sv | 30 +++
 rtl/gf180mcu_fd_sc_mcu7t5v0__xnor3_bist.sv | 123 ++++++++++++
 2 files changed

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__xnor3_bist_if.sv
// rtl/gf180mcu_fd_sc_mcu7t5v0__xnor3_bist_if.sv - pin and result bundle between the XNOR3 BIST and its cell/wrapper
// Purpose: groups the run request, the cell-under-test pins and the result
//          outputs of the XNOR3 BIST sequencer.
// Signals: START (run request), ZN (cell output), A1/A2/A3 (cell inputs),
//          BUSY, DONE, PASS, ERR_CNT[ERR_W], FIRST_FAIL[3].
// Modports: slave = the BIST sequencer, master = the cell/wrapper side.
interface gf180mcu_fd_sc_mcu7t5v0__xnor3_bist_if #(
  parameter int ERR_W = 8
);
  logic             START;
  logic             ZN;
  logic             A1;
  logic             A2;
  logic             A3;
  logic             BUSY;
  logic             DONE;
  logic             PASS;
  logic [ERR_W-1:0] ERR_CNT;
  logic [2:0]       FIRST_FAIL;

  modport slave (
    input  START, ZN,
    output A1, A2, A3, BUSY, DONE, PASS, ERR_CNT, FIRST_FAIL
  );

  modport master (
    output START, ZN,
    input  A1, A2, A3, BUSY, DONE, PASS, ERR_CNT, FIRST_FAIL
  );
endinterface

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__xnor3_bist.sv
// rtl/gf180mcu_fd_sc_mcu7t5v0__xnor3_bist.sv - Gray-code sweep generator and checker for the XNOR3 cell
// Purpose: drives A1/A2/A3 with a Gray-code sweep, checks ZN against the
//          ideal XNOR3 at the end of every hold, and reports pass/fail,
//          a saturating mismatch count and the first failing vector.
// Ports:   CLK  - rising-edge clock
//          RN   - asynchronous active-low reset
//          bus  - slave side of the BIST interface (START, ZN in;
//                 A1..A3, BUSY, DONE, PASS, ERR_CNT, FIRST_FAIL out)
module gf180mcu_fd_sc_mcu7t5v0__xnor3_bist #(
  parameter int PASSES = 2,
  parameter int SETTLE = 2,
  parameter int ERR_W  = 8
) (
  input  logic CLK,
  input  logic RN,
  gf180mcu_fd_sc_mcu7t5v0__xnor3_bist_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state;
  logic [3:0]       hold_cnt;
  logic [2:0]       idx;
  logic [7:0]       pass_cnt;
  logic [2:0]       a_vec;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_cnt;
  logic [2:0]       first_fail;

  logic             hold_last;
  logic             last_sample;
  logic             exp_zn;
  logic             mismatch;
  logic [ERR_W-1:0] err_next;

  // Binary-reflected Gray code: consecutive indices differ in one bit,
  // including the 7 -> 0 wrap between passes.
  function automatic logic [2:0] gray(input logic [2:0] i);
    return i ^ (i >> 1);
  endfunction

  assign hold_last   = (hold_cnt == 4'(SETTLE - 1));
  assign last_sample = (idx == 3'd7) && (pass_cnt == 8'(PASSES - 1));
  assign exp_zn      = ~(a_vec[0] ^ a_vec[1] ^ a_vec[2]);
  // Case inequality so that an X or Z on the cell output is a failure.
  assign mismatch    = (bus.ZN !== exp_zn);
  assign err_next    = (mismatch && (err_cnt != '1)) ? err_cnt + 1'b1 : err_cnt;

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state      <= S_IDLE;
      hold_cnt   <= '0;
      idx        <= '0;
      pass_cnt   <= '0;
      a_vec      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
      first_fail <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.START) begin
            state      <= S_RUN;
            hold_cnt   <= '0;
            idx        <= '0;
            pass_cnt   <= '0;
            a_vec      <= gray(3'd0);
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_cnt    <= '0;
            first_fail <= '0;
          end
        end
        S_RUN: begin
          if (hold_last) begin
            // Sample edge: score the vector that was held, then move on.
            err_cnt <= err_next;
            if (mismatch && (err_cnt == '0)) begin
              first_fail <= a_vec;
            end
            hold_cnt <= '0;
            if (last_sample) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_next == '0);
              idx   <= '0;
              a_vec <= '0;
            end else begin
              idx   <= idx + 3'd1;
              a_vec <= gray(idx + 3'd1);
              if (idx == 3'd7) begin
                pass_cnt <= pass_cnt + 8'd1;
              end
            end
          end else begin
            hold_cnt <= hold_cnt + 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.A1         = a_vec[0];
  assign bus.A2         = a_vec[1];
  assign bus.A3         = a_vec[2];
  assign bus.BUSY       = busy;
  assign bus.DONE       = done;
  assign bus.PASS       = pass;
  assign bus.ERR_CNT    = err_cnt;
  assign bus.FIRST_FAIL = first_fail;

endmodule
